prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writable program memory that replaces the fixed ROM feeding the 4-bit CPU.
- Accepts a framed byte stream over a valid/ready interface and writes the 16x8 instruction store.
- Serves instruction reads to the CPU through the same addr/code pair the CPU already fetches on.
- Holds the CPU in reset while a load is in progress and releases it only after a good checksum.

Parameters:
- AW, 4, address width; store depth is 2**AW = 16 words.
- DW, 8, instruction width.
- SYNC, 8'hA5, frame header byte.
- TIMEOUT, 255, idle cycles allowed between bytes inside a frame before the frame is aborted.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_valid  input  1  byte-stream valid.
- rx_data  input  8  byte-stream data.
- rx_ready  output  1  byte-stream ready; a byte transfers on a clk edge with rx_valid & rx_ready.
- cpu_addr  input  AW  CPU fetch address.
- cpu_code  output  DW  instruction at cpu_addr; combinational read.
- cpu_rst_n  output  1  active-low reset to the CPU; registered.
- load_done  output  1  one-cycle pulse when a frame commits with a good checksum.
- load_err  output  1  sticky flag for a checksum or timeout failure; cleared by the next SYNC accepted.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; all 16 words written to 8'h00.
  - cpu_rst_n=0, rx_ready=0, load_done=0, load_err=0; byte counter, checksum and timeout counter cleared.
- First cycle after reset: rx_ready=1, cpu_rst_n=1. The CPU runs the all-zero program.
- Frame format:
  - SYNC, then exactly 16 payload bytes written to addresses 0..15 in order, then one checksum byte.
  - Checksum = sum of the 16 payload bytes mod 256.
- States:
  - IDLE: CPU running. Accepted bytes other than SYNC are dropped. An accepted SYNC goes to LOAD and clears cnt, sum, timeout and load_err. cpu_rst_n=0 from the next cycle.
  - LOAD: each accepted byte writes mem[cnt], sum+=byte, cnt+=1. The byte accepted with cnt=15 goes to CSUM; cnt wraps to 0. A SYNC value in the payload is data, not a restart.
  - CSUM:
    - Accepted byte == sum: go to COMMIT.
    - Otherwise: load_err=1, go to IDLE, cpu_rst_n stays 0.
  - COMMIT: single cycle with rx_ready=0. load_done=1 for this cycle; cpu_rst_n=1 registered at the end of the cycle. Then IDLE.
- After an error, the CPU stays in reset until a later frame commits. Bytes received in IDLE meanwhile are still dropped.
- Timeout:
  - In LOAD/CSUM the timeout counter increments on every cycle with no accepted byte and clears on every accepted byte.
  - On reaching TIMEOUT: load_err=1, go to IDLE, CPU stays in reset. Memory keeps the partial contents.
- rx_ready=1 in IDLE, LOAD and CSUM; 0 in COMMIT and during reset.
- Read port:
  - cpu_code = mem[cpu_addr], combinational; a write to the same address is visible the cycle after the write edge.
  - cpu_code is don't-care to the CPU while cpu_rst_n=0, but must still reflect memory.
- A SYNC accepted in IDLE while the CPU is running starts a reload. The CPU is held in reset from the following cycle; an in-flight instruction is discarded.
- rst asserted mid-frame: full reset behaviour, with memory cleared and the frame lost.
- Counters are AW bits and wrap naturally. Checksum arithmetic is 8-bit, carry discarded.

Test Plan:
- Reset then idle 5 cycles -> cpu_rst_n=1 from cycle 1, cpu_code=8'h00 for every cpu_addr, load_done=0, load_err=0.
- Frame A5, 01..10, checksum 88 sent back-to-back -> cpu_rst_n=0 from the cycle after A5. load_done pulses exactly once, one cycle after checksum acceptance. cpu_rst_n=1 on the next cycle. mem[k]=k+1.
- Same payload with checksum 87 -> load_err=1, no load_done, cpu_rst_n stays 0. Then a good frame with payload all B3 and checksum 30 -> load_err clears on SYNC, CPU released, all words B3.
- Send A5 plus 7 payload bytes, then hold rx_valid=0 for 255 cycles -> load_err=1, state IDLE, cpu_rst_n=0. mem[0..6] updated and mem[7..15] unchanged.
- Payload containing A5 at positions 3 and 9 with the correct checksum -> treated as data and committed, mem[3]=mem[9]=A5. Stray bytes 12, 34 sent in IDLE before the frame are ignored.
- Assert rst in the middle of payload byte 10 -> next cycle all memory reads 00, cpu_rst_n=0 for one cycle and then 1, load_err=0.

Source files
------------

// File: rtl/prog_loader.sv
// Writable 16x8 program store for the 4-bit CPU, loaded from a framed byte stream.
// Holds the CPU in reset while a frame is in flight and releases it on a good checksum.
module prog_loader #(
    parameter int          AW      = 4,
    parameter int          DW      = 8,
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter int          TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    input  logic [AW-1:0] cpu_addr,
    output logic [DW-1:0] cpu_code,
    output logic          cpu_rst_n,
    output logic          load_done,
    output logic          load_err,
    output logic [1:0]    dbg_state
);
    localparam int DEPTH = 2 ** AW;
    localparam int TW    = $clog2(TIMEOUT + 1);

    // rx_valid/rx_ready: a byte moves on a rising clk edge where both are high;
    // rx_data is only looked at on such an edge, and a byte is never taken back.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CSUM   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t        state;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] cnt;
    logic [7:0]    sum;
    logic [TW-1:0] tmo;
    logic          cpu_hold;
    logic          accept;

    assign accept    = rx_valid & rx_ready;
    assign cpu_code  = mem[cpu_addr];
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            cnt       <= '0;
            sum       <= '0;
            tmo       <= '0;
            cpu_hold  <= 1'b0;
            cpu_rst_n <= 1'b0;
            rx_ready  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    rx_ready  <= 1'b1;
                    // cpu_hold keeps the CPU parked after a failed frame until a good one commits
                    cpu_rst_n <= ~cpu_hold;
                    if (accept && rx_data == SYNC) begin
                        state     <= LOAD;
                        cnt       <= '0;
                        sum       <= '0;
                        tmo       <= '0;
                        load_err  <= 1'b0;
                        cpu_hold  <= 1'b1;
                        cpu_rst_n <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        mem[cnt] <= DW'(rx_data);
                        sum      <= sum + rx_data;
                        cnt      <= cnt + 1'b1;
                        tmo      <= '0;
                        if (cnt == AW'(DEPTH - 1)) state <= CSUM;
                    end else if (tmo == TW'(TIMEOUT - 1)) begin
                        load_err <= 1'b1;
                        tmo      <= '0;
                        state    <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                CSUM: begin
                    if (accept) begin
                        tmo <= '0;
                        if (rx_data == sum) begin
                            state     <= COMMIT;
                            rx_ready  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            load_err <= 1'b1;
                            state    <= IDLE;
                        end
                    end else if (tmo == TW'(TIMEOUT - 1)) begin
                        load_err <= 1'b1;
                        tmo      <= '0;
                        state    <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                COMMIT: begin
                    rx_ready  <= 1'b1;
                    cpu_hold  <= 1'b0;
                    cpu_rst_n <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and random frames against a word-array model,
// with frame outcomes (commit / error) checked by a separate monitor.
module tb_prog_loader;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_code;
    logic       cpu_rst_n;
    logic       load_done;
    logic       load_err;
    logic [1:0] dbg_state;

    prog_loader dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .cpu_addr  (cpu_addr),
        .cpu_code  (cpu_code),
        .cpu_rst_n (cpu_rst_n),
        .load_done (load_done),
        .load_err  (load_err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Outcome codes: 1 = frame committed, 2 = frame failed.
    logic [1:0] exp_q[$];
    logic [7:0] ref_mem [16];
    logic [7:0] pl [16];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each load_done pulse or load_err rise is matched to the next expected outcome.
    logic prev_err = 1'b0;
    always @(negedge clk) begin
        logic [1:0] ev;
        logic [1:0] want;
        ev = 2'd0;
        if (load_done === 1'b1) ev = 2'd1;
        else if (load_err === 1'b1 && prev_err === 1'b0) ev = 2'd2;
        prev_err = (load_err === 1'b1);
        if (ev != 2'd0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_outcome", ev, 0);
            end else begin
                want = exp_q.pop_front();
                chk("frame_outcome", ev, want);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_valid = 1'b1;
        rx_data  = b;
        waited   = 0;
        while (rx_ready !== 1'b1 && waited < 300) begin
            tick();
            waited++;
        end
        if (waited >= 300) chk("rx_ready_timeout", 0, 1);
        tick();
    endtask

    task automatic check_mem(input string tag);
        for (int k = 0; k < 16; k++) begin
            cpu_addr = 4'(k);
            #1;
            chk($sformatf("%s_mem%0d", tag, k), cpu_code, ref_mem[k]);
        end
    endtask

    // Sends SYNC, the 16 words in pl[] and csum; the model decides the outcome from the sum.
    task automatic run_frame(input string tag, input logic [7:0] csum, input int max_gap);
        int  s;
        bit  good;
        s = 0;
        send_byte(SYNC, $urandom_range(0, max_gap));
        chk({tag, "_rstn_after_sync"}, cpu_rst_n, 0);
        chk({tag, "_err_clr_on_sync"}, load_err, 0);
        for (int k = 0; k < 16; k++) begin
            send_byte(pl[k], $urandom_range(0, max_gap));
            ref_mem[k] = pl[k];
            s = s + int'(pl[k]);
        end
        good = (csum == 8'(s % 256));
        exp_q.push_back(good ? 2'd1 : 2'd2);
        send_byte(csum, $urandom_range(0, max_gap));
        rx_valid = 1'b0;
        chk({tag, "_done_pulse"}, load_done, good);
        tick();
        chk({tag, "_done_single"}, load_done, 0);
        chk({tag, "_rstn_after"}, cpu_rst_n, good);
        chk({tag, "_err_after"}, load_err, !good);
        check_mem(tag);
    endtask

    initial begin
        int s;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        cpu_addr = 4'd0;
        for (int k = 0; k < 16; k++) ref_mem[k] = 8'h00;

        // Reset and idle
        repeat (2) tick();
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_cpu_rst_n", cpu_rst_n, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_rx_ready", rx_ready, 1);
        chk("post_rst_cpu_rst_n", cpu_rst_n, 1);
        chk("post_rst_load_done", load_done, 0);
        chk("post_rst_load_err", load_err, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_cpu_rst_n", cpu_rst_n, 1);
        end
        check_mem("reset");

        // Counting payload, good then bad checksum
        for (int k = 0; k < 16; k++) pl[k] = 8'(k + 1);
        run_frame("count_good", 8'h88, 0);
        run_frame("count_bad", 8'h87, 0);

        for (int k = 0; k < 16; k++) pl[k] = 8'hB3;
        run_frame("b3_good", 8'h30, 1);

        // Timeout after 7 payload bytes
        for (int k = 0; k < 16; k++) pl[k] = 8'($urandom_range(0, 255));
        send_byte(SYNC, 0);
        for (int k = 0; k < 7; k++) begin
            send_byte(pl[k], 0);
            ref_mem[k] = pl[k];
        end
        rx_valid = 1'b0;
        exp_q.push_back(2'd2);
        repeat (TIMEOUT - 1) tick();
        chk("tmo_not_yet", load_err, 0);
        tick();
        chk("tmo_err", load_err, 1);
        chk("tmo_state_idle", dbg_state, 0);
        chk("tmo_cpu_rst_n", cpu_rst_n, 0);
        check_mem("tmo");

        // Stray bytes in IDLE, then SYNC values inside the payload
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        rx_valid = 1'b0;
        tick();
        chk("stray_state_idle", dbg_state, 0);
        chk("stray_cpu_rst_n", cpu_rst_n, 0);
        check_mem("stray");
        s = 0;
        for (int k = 0; k < 16; k++) begin
            pl[k] = (k == 3 || k == 9) ? SYNC : 8'($urandom_range(0, 255));
            s += int'(pl[k]);
        end
        run_frame("sync_data", 8'(s % 256), 2);

        // Random frames, randomly good or corrupted checksum
        for (int f = 0; f < 4; f++) begin
            s = 0;
            for (int k = 0; k < 16; k++) begin
                pl[k] = 8'($urandom_range(0, 255));
                s += int'(pl[k]);
            end
            if ($urandom_range(0, 1) == 1) run_frame("rand_good", 8'(s % 256), 3);
            else run_frame("rand_bad", 8'((s + int'($urandom_range(1, 255))) % 256), 3);
        end

        // Reset in the middle of payload byte 10
        for (int k = 0; k < 16; k++) pl[k] = 8'($urandom_range(0, 255));
        send_byte(SYNC, 0);
        for (int k = 0; k < 10; k++) send_byte(pl[k], 0);
        rx_valid = 1'b1;
        rx_data  = pl[10];
        rst      = 1'b1;
        tick();
        rx_valid = 1'b0;
        for (int k = 0; k < 16; k++) ref_mem[k] = 8'h00;
        chk("midrst_cpu_rst_n", cpu_rst_n, 0);
        chk("midrst_load_err", load_err, 0);
        chk("midrst_rx_ready", rx_ready, 0);
        check_mem("midrst");
        rst = 1'b0;
        tick();
        chk("midrst_release", cpu_rst_n, 1);
        chk("midrst_state_idle", dbg_state, 0);

        repeat (3) tick();
        chk("outcomes_pending", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
